boot_loader: RTL and testbench
==============================

BOOT_LOADER -- requirements
Module: boot_loader

Interface
REQ-001 Parameter ADDR_WIDTH, default 10: instruction-memory word-address width.
REQ-002 Parameter BASE_ADDR, default 0: first word address written.
REQ-003 Parameter MAGIC, default 16'hB007: required header tag.
REQ-004 clock  in  1  sole clock; all state changes on posedge.
REQ-005 rst  in  1  reset; synchronous, active-low.
REQ-006 start  in  1  begin a load session (level sampled each cycle).
REQ-007 in_valid  in  1  source presents a word.
REQ-008 in_data  in  32  word from BIOS/serial source.
REQ-009 in_ready  out  1  loader accepts in_data this cycle.
REQ-010 mem_we  out  1  instruction-memory write strobe.
REQ-011 mem_addr  out  ADDR_WIDTH  write word address.
REQ-012 mem_wdata  out  32  write data.
REQ-013 busy  out  1  session in progress (HEADER, LOAD or CHECK).
REQ-014 done  out  1  program loaded and verified; drives the instruction selector's source input.
REQ-015 err  out  1  session aborted.

Function
REQ-016 The FSM SHALL have states IDLE, HEADER, LOAD, CHECK, DONE and ERR; a handshake is in_valid && in_ready.
REQ-017 IDLE: in_ready=0; start=1 -> HEADER.
REQ-018 HEADER: in_ready=1; on handshake, in_data[31:16]!=MAGIC -> ERR; else N=in_data[15:0].
REQ-019 HEADER with N=0 -> CHECK; with BASE_ADDR+N > 2**ADDR_WIDTH -> ERR; otherwise -> LOAD, with word counter and checksum cleared.
REQ-020 LOAD: in_ready=1; on each handshake, the loader SHALL add in_data to a 32-bit checksum (mod 2**32) and increment the counter.
REQ-021 Each LOAD handshake SHALL produce exactly one mem_we pulse on the following cycle, with mem_addr=BASE_ADDR+k and mem_wdata=word k (k from 0); outputs are registered.
REQ-022 When the handshake accepting word N-1 occurs, the FSM SHALL go to CHECK.
REQ-023 CHECK: in_ready=1; on handshake, in_data equal to the checksum -> DONE, otherwise -> ERR; N=0 expects checksum 0.
REQ-024 Cycles with in_valid=0 SHALL hold all state; there is no timeout.
REQ-025 DONE: done=1, in_ready=0; start=1 -> HEADER, clearing done the same cycle.
REQ-026 ERR: err=1, in_ready=0, done=0; start=1 -> HEADER, clearing err.
REQ-027 start SHALL be ignored in HEADER, LOAD and CHECK.
REQ-028 busy=1 exactly in HEADER, LOAD and CHECK.
REQ-029 in_ready SHALL be a function of state only; it SHALL NOT depend combinationally on in_valid.
REQ-030 done and err SHALL never both be 1.
REQ-031 mem_we SHALL be 0 in every cycle not described by REQ-021.
REQ-032 Writes SHALL NOT wrap: an address at or above 2**ADDR_WIDTH is never issued.

Reset
REQ-033 rst=0 at a posedge SHALL force state IDLE and in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0, err=0, and SHALL clear the counter and checksum.
REQ-034 Reset mid-session SHALL abort with no further mem_we pulse, including a write pending from the handshake in the reset cycle.
REQ-035 With rst=0, start and in_valid SHALL be ignored.

Verification
REQ-036 Nominal load: start, header 32'hB0070003, words 1,2,3, checksum 6 -> mem_we at addresses 0,1,2 with data 1,2,3, then done=1, busy=0.
REQ-037 Bad magic: header 32'hDEAD0003 -> err=1, no mem_we, in_ready=0.
REQ-038 Checksum fail: header 32'hB0070002, words 5,5, checksum 9 -> two writes occur, then err=1, done=0.
REQ-039 Stalls and overflow: in_valid toggled randomly in LOAD -> same writes as without stalls; with ADDR_WIDTH=2 and header N=5 -> err=1.
REQ-040 Reset mid-LOAD after word 1 -> all outputs 0 the next cycle, no further mem_we; a fresh start/N=0/checksum 0 -> done=1.

Source files
------------

// File: rtl/boot_loader.sv
// Boot loader: accepts a MAGIC/length header, streams N words into instruction
// memory with a running 32-bit checksum, then verifies a trailing checksum word.
module boot_loader #(
    parameter int          ADDR_WIDTH = 10,
    parameter int          BASE_ADDR  = 0,
    parameter logic [15:0] MAGIC      = 16'hB007
) (
    input  logic                  clock,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  in_valid,
    input  logic [31:0]           in_data,
    output logic                  in_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HEADER,
        S_LOAD,
        S_CHECK,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [32:0] MEM_WORDS = 33'd1 << ADDR_WIDTH;

    state_t                  state_q;
    logic [15:0]             n_q;
    logic [15:0]             cnt_q;
    logic [31:0]             csum_q;
    logic                    rdy_q;
    logic                    we_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [31:0]             wdata_q;
    logic                    busy_q;
    logic                    done_q;
    logic                    err_q;

    logic                    hs_d;
    logic [32:0]             end_addr_d;
    logic                    ovf_d;

    assign hs_d       = in_valid && rdy_q;
    // One past the last address the header would write; must not exceed memory size.
    assign end_addr_d = 33'(BASE_ADDR) + {17'd0, in_data[15:0]};
    assign ovf_d      = end_addr_d > MEM_WORDS;

    always_ff @(posedge clock) begin
        if (!rst) begin
            state_q <= S_IDLE;
            n_q     <= '0;
            cnt_q   <= '0;
            csum_q  <= '0;
            rdy_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            we_q <= 1'b0;
            case (state_q)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start) begin
                        state_q <= S_HEADER;
                        rdy_q   <= 1'b1;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                        err_q   <= 1'b0;
                        cnt_q   <= '0;
                        csum_q  <= '0;
                    end
                end
                S_HEADER: begin
                    if (hs_d) begin
                        n_q    <= in_data[15:0];
                        cnt_q  <= '0;
                        csum_q <= '0;
                        if (in_data[31:16] != MAGIC || (in_data[15:0] != 16'd0 && ovf_d)) begin
                            state_q <= S_ERR;
                            err_q   <= 1'b1;
                            rdy_q   <= 1'b0;
                            busy_q  <= 1'b0;
                        end else if (in_data[15:0] == 16'd0) begin
                            state_q <= S_CHECK;
                        end else begin
                            state_q <= S_LOAD;
                        end
                    end
                end
                S_LOAD: begin
                    if (hs_d) begin
                        we_q    <= 1'b1;
                        addr_q  <= ADDR_WIDTH'(BASE_ADDR) + ADDR_WIDTH'(cnt_q);
                        wdata_q <= in_data;
                        csum_q  <= csum_q + in_data;
                        cnt_q   <= cnt_q + 16'd1;
                        if (cnt_q == n_q - 16'd1)
                            state_q <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (hs_d) begin
                        rdy_q  <= 1'b0;
                        busy_q <= 1'b0;
                        if (in_data == csum_q) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= S_ERR;
                            err_q   <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    rdy_q   <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    err_q   <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = rdy_q;
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_boot_loader.sv
// Randomized bench: two loaders (default and a 4-word memory at base 1) share one
// input stream; a session-level model predicts writes and final done/err.
module tb_boot_loader;

    logic        clock = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = '0;

    logic        b_rdy, b_we, b_busy, b_done, b_err;
    logic [9:0]  b_addr;
    logic [31:0] b_wdata;
    logic        s_rdy, s_we, s_busy, s_done, s_err;
    logic [1:0]  s_addr;
    logic [31:0] s_wdata;

    int nvec = 0;
    int nerr = 0;
    bit mon_en = 1'b0;
    bit stall_en = 1'b0;

    logic [63:0] got_b[$], got_s[$], exp_b[$], exp_s[$];
    logic [31:0] words[$];

    always #5 clock = ~clock;

    boot_loader u_big (
        .clock(clock), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(b_rdy), .mem_we(b_we), .mem_addr(b_addr), .mem_wdata(b_wdata),
        .busy(b_busy), .done(b_done), .err(b_err)
    );

    boot_loader #(.ADDR_WIDTH(2), .BASE_ADDR(1)) u_sml (
        .clock(clock), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(s_rdy), .mem_we(s_we), .mem_addr(s_addr), .mem_wdata(s_wdata),
        .busy(s_busy), .done(s_done), .err(s_err)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        if (mon_en) begin
            if (b_we) got_b.push_back({32'(b_addr), b_wdata});
            if (s_we) got_s.push_back({32'(s_addr), s_wdata});
            chk("excl_b", 64'(b_done & b_err), 64'd0);
            chk("excl_s", 64'(s_done & s_err), 64'd0);
            chk("rdy_busy_b", 64'(b_rdy), 64'(b_busy));
            chk("rdy_busy_s", 64'(s_rdy), 64'(s_busy));
        end
    end

    task automatic chk_zero(input string tag);
        chk({tag, "_b"}, 64'({b_rdy, b_we, b_addr, b_wdata, b_busy, b_done, b_err}), 64'd0);
        chk({tag, "_s"}, 64'({s_rdy, s_we, s_addr, s_wdata, s_busy, s_done, s_err}), 64'd0);
    endtask

    // Called at a negedge; returns at the negedge after the handshake.
    task automatic drive_word(input logic [31:0] d, input bit exp_we, input bit noise);
        if (stall_en) begin
            repeat ($urandom_range(0, 3)) begin
                in_valid = 1'b0;
                in_data  = $urandom;
                if (noise) start = 1'($urandom_range(0, 1));
                @(negedge clock);
            end
        end
        start = 1'b0;
        chk("rdy_pre", 64'(b_rdy), 64'd1);
        in_valid = 1'b1;
        in_data  = d;
        @(negedge clock);
        in_valid = 1'b0;
        chk("we_lat", 64'(b_we), 64'(exp_we));
    endtask

    task automatic cmp_writes(input string tag);
        chk({tag, "_nb"}, 64'(got_b.size()), 64'(exp_b.size()));
        chk({tag, "_ns"}, 64'(got_s.size()), 64'(exp_s.size()));
        foreach (exp_b[k]) chk({tag, "_wb"}, (k < got_b.size()) ? got_b[k] : '1, exp_b[k]);
        foreach (exp_s[k]) chk({tag, "_ws"}, (k < got_s.size()) ? got_s[k] : '1, exp_s[k]);
    endtask

    // Session model: header tag and length decide acceptance for each memory size,
    // accepted words land at base+k, and the result is ck == sum of words mod 2^32.
    task automatic run_session(input string tag, input logic [31:0] hdr, input logic [31:0] ck);
        bit          magic_ok, big_ok, sml_ok, sum_ok;
        int          n;
        logic [31:0] sum;
        got_b.delete(); got_s.delete(); exp_b.delete(); exp_s.delete();
        magic_ok = (hdr[31:16] == 16'hB007);
        n        = int'(hdr[15:0]);
        big_ok   = magic_ok && (n <= 1024);
        sml_ok   = magic_ok && (1 + n <= 4);
        sum = '0;
        foreach (words[k]) sum += words[k];
        sum_ok = (ck == sum);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        drive_word(hdr, 1'b0, sml_ok);
        if (big_ok) begin
            foreach (words[k]) drive_word(words[k], 1'b1, sml_ok);
            drive_word(ck, 1'b0, sml_ok);
        end
        repeat (2) @(negedge clock);
        if (big_ok) foreach (words[k]) exp_b.push_back({32'(k), words[k]});
        if (sml_ok) foreach (words[k]) exp_s.push_back({32'(k + 1), words[k]});
        cmp_writes(tag);
        chk({tag, "_done_b"}, 64'(b_done), 64'(big_ok && sum_ok));
        chk({tag, "_err_b"},  64'(b_err),  64'(!(big_ok && sum_ok)));
        chk({tag, "_done_s"}, 64'(s_done), 64'(sml_ok && sum_ok));
        chk({tag, "_err_s"},  64'(s_err),  64'(!(sml_ok && sum_ok)));
        chk({tag, "_busy"},   64'({b_busy, s_busy, b_rdy, s_rdy}), 64'd0);
    endtask

    task automatic set_words(input int n);
        words.delete();
        for (int k = 0; k < n; k++) words.push_back($urandom);
    endtask

    initial begin
        logic [31:0] hdr, ck, sum;
        int          n;
        // Reset with start and in_valid active: both must be ignored.
        start = 1'b1; in_valid = 1'b1; in_data = 32'hB0070001;
        repeat (3) @(negedge clock);
        mon_en = 1'b1;
        chk_zero("rst");
        rst = 1'b1; start = 1'b0; in_valid = 1'b0;
        @(negedge clock);
        chk("idle_busy", 64'({b_busy, s_busy, b_done, b_err}), 64'd0);

        words = '{32'd1, 32'd2, 32'd3};
        run_session("nominal", 32'hB0070003, 32'd6);
        words.delete();
        run_session("badmagic", 32'hDEAD0003, 32'd0);
        words = '{32'd5, 32'd5};
        run_session("badsum", 32'hB0070002, 32'd9);
        words.delete();
        run_session("n0_ok", 32'hB0070000, 32'd0);
        run_session("n0_bad", 32'hB0070000, 32'd1);
        run_session("ovf_big", 32'hB0070401, 32'd0);

        stall_en = 1'b1;
        words = '{32'd1, 32'd2, 32'd3};
        run_session("stall_nom", 32'hB0070003, 32'd6);
        for (int m = 3; m <= 5; m++) begin
            set_words(m);
            sum = '0;
            foreach (words[k]) sum += words[k];
            run_session("sml_edge", {16'hB007, 16'(m)}, sum);
        end
        set_words(1024);
        sum = '0;
        foreach (words[k]) sum += words[k];
        run_session("full_big", 32'hB0070400, sum);

        for (int it = 0; it < 40; it++) begin
            n = $urandom_range(0, 6);
            set_words(n);
            hdr = {16'hB007, 16'(n)};
            if ($urandom_range(0, 7) == 0) hdr[31:16] = 16'($urandom);
            sum = '0;
            foreach (words[k]) sum += words[k];
            ck = sum;
            if ($urandom_range(0, 3) == 0) ck = sum ^ (32'd1 << $urandom_range(0, 31));
            run_session("rand", hdr, ck);
        end

        // Reset during LOAD, with a handshake landing in the reset cycle.
        stall_en = 1'b0;
        got_b.delete(); got_s.delete(); exp_b.delete(); exp_s.delete();
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        drive_word(32'hB0070003, 1'b0, 1'b1);
        drive_word(32'd1, 1'b1, 1'b1);
        rst = 1'b0; in_valid = 1'b1; in_data = 32'd2; start = 1'b1;
        @(negedge clock);
        chk_zero("midrst");
        rst = 1'b1; in_valid = 1'b0; start = 1'b0;
        repeat (3) @(negedge clock);
        exp_b.push_back({32'd0, 32'd1});
        exp_s.push_back({32'd1, 32'd1});
        cmp_writes("midrst");
        chk("midrst_idle", 64'({b_busy, s_busy, b_done, b_err, s_done, s_err}), 64'd0);
        words.delete();
        run_session("post_rst", 32'hB0070000, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
